out_capture_buffer: RTL
=======================

OUT_CAPTURE_BUFFER -- requirements
Module: out_capture_buffer

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, width of monitored bus (uo_out concatenated with uio_out).
REQ-002 SHALL provide parameter DEPTH, default 16, FIFO entries, power of two, minimum 2.
REQ-003 SHALL provide parameter TS_W, default 12, timestamp width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  global enable; when 0, state, FIFO and timestamp hold and no push occurs.
REQ-007 mon_in  input  DATA_W  monitored bus.
REQ-008 mode  input  1  0 = capture on change, 1 = capture every cycle.
REQ-009 trig_mask / trig_val  input  DATA_W each  trigger compare mask and value.
REQ-010 arm / abort  input  1 each  single-cycle control pulses.
REQ-011 rd_ready  input  1  consumer accepts head entry.
REQ-012 rd_valid  output  1  FIFO non-empty.
REQ-013 rd_data  output  TS_W+DATA_W  head entry {timestamp, sample}; 0 when empty.
REQ-014 level  output  clog2(DEPTH)+1  current occupancy.
REQ-015 state_o  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 overflow  output  1  sticky, a required sample was dropped.

Function
REQ-017 FSM: IDLE --arm--> ARMED; ARMED --trigger--> CAPTURE; CAPTURE --drop--> DONE; DONE --arm--> ARMED; ARMED/CAPTURE/DONE --abort--> IDLE.
REQ-018 Trigger: ((mon_in ^ trig_val) & trig_mask) == 0 while ARMED; trig_mask all-zero triggers on first ARMED cycle.
REQ-019 Arm accepted only in IDLE or DONE; ignored in ARMED/CAPTURE.
REQ-020 Accepted arm clears FIFO (level 0), overflow and timestamp in the same edge.
REQ-021 Abort has priority over arm and trigger in the same cycle; abort preserves FIFO contents and overflow.
REQ-022 Trigger cycle always pushes {0, mon_in}, regardless of mode.
REQ-023 In CAPTURE, push required when mode=1, or when mode=0 and mon_in != previous-cycle mon_in.
REQ-024 Previous-sample register updates every enabled cycle in ARMED and CAPTURE.
REQ-025 Timestamp cleared to 0 on trigger edge, increments by 1 each enabled CAPTURE cycle, saturates at 2^TS_W-1.
REQ-026 Pushed entry carries timestamp of its capture cycle (trigger entry = 0, next cycle = 1).
REQ-027 Latency: sample captured at edge N appears on rd_data/rd_valid after edge N, i.e. visible in cycle N+1.
REQ-028 Pop on rd_valid & rd_ready at clock edge; rd_ready while empty has no effect.
REQ-029 Simultaneous push and pop: level unchanged, both take effect, including when full.
REQ-030 Push required with FIFO full and no pop: sample dropped, overflow set, FSM to DONE next edge.
REQ-031 Pointers wrap modulo DEPTH; level never exceeds DEPTH nor goes below 0.
REQ-032 Pops permitted in every state, including IDLE and DONE.

Reset
REQ-033 rst_n low SHALL immediately force: state_o=IDLE, level=0, rd_valid=0, rd_data=0, overflow=0, timestamp=0, previous-sample register=0.
REQ-034 Reset mid-capture SHALL discard FIFO contents; first edge after deassertion behaves as IDLE.

Verification
REQ-035 Arm, trig_mask=0x00FF, trig_val=0x0042, mon_in 0x0000 then 0x1242 -> CAPTURE, first entry {0,0x1242}, rd_valid one cycle later.
REQ-036 mode=0, mon_in 0x11,0x11,0x22,0x22,0x33 after trigger at 0x11 -> entries {0,0x11},{2,0x22},{4,0x33}.
REQ-037 DEPTH=16, mode=1, rd_ready=0 -> 16 entries, level=16, 17th cycle overflow=1, state DONE, head still timestamp 0.
REQ-038 Full FIFO, mode=1, rd_ready=1 continuously -> level stays 16, no overflow, timestamps consecutive.
REQ-039 arm and abort same cycle in IDLE -> stays IDLE; abort in CAPTURE with 5 entries -> IDLE, level=5, entries still readable.
REQ-040 rst_n pulsed low mid-CAPTURE with level=7 -> asynchronous clear, level=0, rd_valid=0, state IDLE before next edge.

Source files
------------

// File: rtl/out_capture_buffer_if.sv
// Bundle of the capture buffer's control, monitored-bus and read-side signals.
//   master : drives ena, mon_in, mode, trig_mask, trig_val, arm, abort, rd_ready;
//            observes rd_valid, rd_data, level, state_o, overflow
//   slave  : the capture buffer itself (opposite directions)
interface out_capture_buffer_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 12,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                   ena;
  logic [DATA_W-1:0]      mon_in;
  logic                   mode;
  logic [DATA_W-1:0]      trig_mask;
  logic [DATA_W-1:0]      trig_val;
  logic                   arm;
  logic                   abort;
  logic                   rd_ready;
  logic                   rd_valid;
  logic [TS_W+DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]       level;
  logic [1:0]             state_o;
  logic                   overflow;

  modport master (
    output ena, mon_in, mode, trig_mask, trig_val, arm, abort, rd_ready,
    input  rd_valid, rd_data, level, state_o, overflow
  );

  modport slave (
    input  ena, mon_in, mode, trig_mask, trig_val, arm, abort, rd_ready,
    output rd_valid, rd_data, level, state_o, overflow
  );
endinterface

// File: rtl/out_capture_buffer.sv
// Triggered capture buffer for a monitored output bus. Once armed, waits for
// the masked trigger match, then records {timestamp, sample} entries into a
// FIFO either on every cycle or only when the bus changes.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : out_capture_buffer_if.slave (controls, monitored bus, FIFO read side)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | inactive; waits for arm
// ARMED    | FIFO cleared; waits for the masked trigger match
// CAPTURE  | recording samples with a running timestamp
// DONE     | stopped after a dropped sample; waits for re-arm
module out_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 12
) (
  input logic               clk,
  input logic               rst_n,
  out_capture_buffer_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int ENT_W = TS_W + DATA_W;

  localparam logic [TS_W-1:0]  TS_MAX  = '1;
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              overflow_q, overflow_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              empty, full, pop, push, need_push, clear, trig_hit;
  logic [TS_W-1:0]   ts_inc, push_ts;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_FULL);
    pop      = bus.ena && bus.rd_ready && !empty;
    trig_hit = (((bus.mon_in ^ bus.trig_val) & bus.trig_mask) == '0);
    ts_inc   = (ts_q == TS_MAX) ? ts_q : ts_q + TS_ONE;

    state_d    = state_q;
    ts_d       = ts_q;
    prev_d     = prev_q;
    overflow_d = overflow_q;
    need_push  = 1'b0;
    push_ts    = '0;
    clear      = 1'b0;

    if (bus.ena) begin
      if (state_q == ST_ARMED || state_q == ST_CAPTURE) prev_d = bus.mon_in;
      case (state_q)
        ST_IDLE: begin
          // abort in IDLE only serves to mask a simultaneous arm
          if (!bus.abort && bus.arm) begin
            state_d = ST_ARMED;
            clear   = 1'b1;
          end
        end
        ST_ARMED: begin
          if (bus.abort) state_d = ST_IDLE;
          else if (trig_hit) begin
            state_d   = ST_CAPTURE;
            ts_d      = '0;
            push_ts   = '0;
            need_push = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (bus.abort) state_d = ST_IDLE;
          else begin
            // ts_q holds the previous capture cycle's stamp, so this cycle is +1
            ts_d      = ts_inc;
            push_ts   = ts_inc;
            need_push = bus.mode || (bus.mon_in != prev_q);
          end
        end
        default: begin
          if (bus.abort) state_d = ST_IDLE;
          else if (bus.arm) begin
            state_d = ST_ARMED;
            clear   = 1'b1;
          end
        end
      endcase
    end

    // a pop in the same edge frees the slot, so full only blocks without one
    push = need_push && (!full || pop);
    if (need_push && !push) begin
      overflow_d = 1'b1;
      state_d    = ST_DONE;
    end
    if (clear) begin
      overflow_d = 1'b0;
      ts_d       = '0;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ts_q       <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  // storage needs no reset: rd_data is masked to zero whenever level is 0
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_ts, bus.mon_in};
  end

  assign bus.rd_valid = !empty;
  assign bus.rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.level    = level_q;
  assign bus.state_o  = state_q;
  assign bus.overflow = overflow_q;
endmodule
